program_loader: RTL and testbench

//   Boot-time loader upstream of the CPU core. Receives a framed program image as a

---
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: assembles a framed UART byte stream into 16-bit instruction words,
// writes them to instruction memory and releases the core once the checksum passes.
module program_loader #(
    parameter int unsigned INST_ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    output logic                       o_wr_en,
    output logic [INST_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [15:0]                o_wr_data,
    output logic                       o_core_hold,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t                     r_state;
    logic [INST_ADDR_WIDTH-1:0] r_len;
    logic [INST_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                 r_hi;
    logic [7:0]                 r_sum;
    logic [TW-1:0]              r_timer;
    logic                       r_wr_en;
    logic [INST_ADDR_WIDTH-1:0] r_wr_addr;
    logic [15:0]                r_wr_data;
    logic                       r_hold;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_error;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= WAIT_SYNC;
            r_len     <= '0;
            r_addr    <= '0;
            r_hi      <= '0;
            r_sum     <= '0;
            r_timer   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_hold    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (i_rx_valid) begin
                r_timer <= '0;
                case (r_state)
                    WAIT_SYNC, DONE, ERROR: begin
                        if (i_rx_data == SYNC_BYTE) begin
                            r_state <= LEN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_error <= 1'b0;
                            r_hold  <= 1'b1;
                        end
                    end
                    LEN: begin
                        r_len   <= i_rx_data[INST_ADDR_WIDTH-1:0];
                        r_sum   <= i_rx_data;
                        r_addr  <= '0;
                        r_state <= DATA_HI;
                    end
                    DATA_HI: begin
                        r_hi    <= i_rx_data;
                        r_sum   <= r_sum + i_rx_data;
                        r_state <= DATA_LO;
                    end
                    DATA_LO: begin
                        r_sum     <= r_sum + i_rx_data;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= {r_hi, i_rx_data};
                        if (r_addr == r_len) begin
                            r_state <= CHECK;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= DATA_HI;
                        end
                    end
                    CHECK: begin
                        r_busy <= 1'b0;
                        if (i_rx_data == r_sum) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end
                    end
                    default: r_state <= WAIT_SYNC;
                endcase
            end else if (r_busy) begin
                // r_busy is high exactly in LEN..CHECK, so it doubles as the timer enable
                if (r_timer == TLAST) begin
                    r_timer <= '0;
                    r_state <= ERROR;
                    r_busy  <= 1'b0;
                    r_error <= 1'b1;
                    r_hold  <= 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_core_hold = r_hold;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, checksum pass/fail, resync, 256-word
// image, inter-byte timeout and mid-frame reset.
module tb_program_loader;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;

    int checks;
    int failures;
    int nwrites;
    logic [15:0] mem [256];

    program_loader #(
        .INST_ADDR_WIDTH(8),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_core_hold(core_hold),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write capture on the falling edge: each cycle of o_wr_en counts as one write.
    always @(negedge clk) begin
        if (wr_en) begin
            mem[wr_addr] = wr_data;
            nwrites = nwrites + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; consecutive calls give back-to-back bytes.
    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame1();
        put(8'hA5); put(8'h00); put(8'h12); put(8'h34); put(8'h46);
        idle(2);
    endtask

    initial begin
        int bad;
        checks   = 0;
        failures = 0;
        nwrites  = 0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rst      = 1'b1;
        idle(3);
        check("rst_hold",  {31'd0, core_hold}, 32'd1);
        check("rst_flags", {28'd0, wr_en, busy, done, error}, 32'd0);
        check("rst_wr",    {8'd0, wr_addr, wr_data}, 32'd0);
        rst = 1'b0;
        idle(1);

        // 1: single word
        frame1();
        check("t1_nwr",   nwrites, 32'd1);
        check("t1_mem0",  mem[0], 32'h1234);
        check("t1_flags", {28'd0, core_hold, busy, done, error}, 32'b0010);

        // 2: two words, good then bad checksum
        nwrites = 0;
        put(8'hA5); put(8'h01); put(8'hAB); put(8'hCD); put(8'h00); put(8'h01); put(8'h7A);
        idle(2);
        check("t2_nwr",   nwrites, 32'd2);
        check("t2_mem0",  mem[0], 32'hABCD);
        check("t2_mem1",  mem[1], 32'h0001);
        check("t2_done",  {28'd0, core_hold, busy, done, error}, 32'b0010);
        put(8'hA5);
        check("t2_restart", {28'd0, core_hold, busy, done, error}, 32'b1100);
        nwrites = 0;
        mem[0] = 16'h0000;
        mem[1] = 16'h0000;
        put(8'h01); put(8'hAB); put(8'hCD); put(8'h00); put(8'h01); put(8'h7B);
        idle(2);
        check("t2b_nwr",  nwrites, 32'd2);
        check("t2b_mem1", mem[1], 32'h0001);
        check("t2b_err",  {28'd0, core_hold, busy, done, error}, 32'b1001);

        // 3: junk bytes ignored, then a frame whose data equals SYNC_BYTE
        put(8'h00); put(8'hFF);
        idle(1);
        check("t3_ignored", {28'd0, core_hold, busy, done, error}, 32'b1001);
        nwrites = 0;
        put(8'hA5); put(8'h00); put(8'hA5); put(8'hA5); put(8'h4A);
        idle(2);
        check("t3_nwr",   nwrites, 32'd1);
        check("t3_mem0",  mem[0], 32'hA5A5);
        check("t3_done",  {28'd0, core_hold, busy, done, error}, 32'b0010);

        // 4: full 256-word image, CK = FF + sum(0..255) mod 256 = 7F
        nwrites = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        put(8'hA5); put(8'hFF);
        for (int i = 0; i < 256; i++) begin
            put(8'h00);
            put(8'(i));
        end
        put(8'h7F);
        idle(2);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 16'(i)) bad++;
        check("t4_nwr",   nwrites, 32'd256);
        check("t4_bad",   bad, 32'd0);
        check("t4_done",  {28'd0, core_hold, busy, done, error}, 32'b0010);

        // 5: timeout, timer cleared by each byte
        put(8'hA5); put(8'h03); put(8'h12);
        idle(12);
        check("t5_busy1", {28'd0, core_hold, busy, done, error}, 32'b1100);
        put(8'h34);
        idle(12);
        check("t5_busy2", {28'd0, core_hold, busy, done, error}, 32'b1100);
        idle(8);
        check("t5_tmo",   {28'd0, core_hold, busy, done, error}, 32'b1001);
        nwrites = 0;
        frame1();
        check("t5_reload", {28'd0, core_hold, busy, done, error}, 32'b0010);
        check("t5_nwr",    nwrites, 32'd1);

        // 6: reset mid-frame (after DATA_HI)
        put(8'hA5); put(8'h01); put(8'hAB);
        rst = 1'b1;
        #1;
        check("t6_flags", {28'd0, wr_en, busy, done, error}, 32'd0);
        check("t6_hold",  {31'd0, core_hold}, 32'd1);
        check("t6_wr",    {8'd0, wr_addr, wr_data}, 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        nwrites = 0;
        mem[0] = 16'h0000;
        frame1();
        check("t6_nwr",   nwrites, 32'd1);
        check("t6_mem0",  mem[0], 32'h1234);
        check("t6_done",  {28'd0, core_hold, busy, done, error}, 32'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
